// File: rtl/rr_arb_4.sv
// ============================================================================
// Module   : rr_arb_4
// Brief    : 4-requester round-robin arbiter with registered one-hot grant,
//            grant hold until release, and an optional hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_4 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic done,
    output logic g0,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic busy,
    output logic timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           r_state, w_state_n;
    logic [3:0]       r_grant, w_grant_n;
    logic [1:0]       r_owner, w_owner_n;
    logic [1:0]       r_ptr,   w_ptr_n;
    logic [CNT_W-1:0] r_cnt,   w_cnt_n;
    logic             r_busy;
    logic             r_timeout, w_timeout_n;

    logic [3:0]       w_req;
    logic             w_found;
    logic [1:0]       w_pick;
    logic             w_rel_drop;
    logic             w_rel_to;

    assign w_req = {req3, req2, req1, req0};

    // Rotating priority scan starting at r_ptr; the first hit wins.
    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        idx     = r_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = r_ptr + 2'(i);
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    assign w_rel_drop = ~w_req[r_owner];
    assign w_rel_to   = (HOLD_MAX != 0) && (r_cnt == C_HOLD_LAST);

    always_comb begin
        w_state_n   = r_state;
        w_grant_n   = r_grant;
        w_owner_n   = r_owner;
        w_ptr_n     = r_ptr;
        w_cnt_n     = r_cnt;
        w_timeout_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_n = 4'b0000;
                if (w_found) begin
                    w_state_n = ST_GRANT;
                    w_grant_n = 4'b0001 << w_pick;
                    w_owner_n = w_pick;
                    w_cnt_n   = '0;
                end
            end
            ST_GRANT: begin
                // Saturate so the count never wraps when there is no timeout.
                if (r_cnt != '1) begin
                    w_cnt_n = r_cnt + 1'b1;
                end
                if (done || w_rel_drop || w_rel_to) begin
                    w_state_n   = ST_IDLE;
                    w_grant_n   = 4'b0000;
                    w_ptr_n     = r_owner + 2'd1;
                    w_timeout_n = w_rel_to && !done && !w_rel_drop;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_grant_n = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 4'b0000;
            r_owner   <= 2'd0;
            r_ptr     <= 2'd0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_grant   <= w_grant_n;
            r_owner   <= w_owner_n;
            r_ptr     <= w_ptr_n;
            r_cnt     <= w_cnt_n;
            r_busy    <= |w_grant_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign g0      = r_grant[0];
    assign g1      = r_grant[1];
    assign g2      = r_grant[2];
    assign g3      = r_grant[3];
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_4.sv
// ============================================================================
// Module   : tb_rr_arb_4
// Brief    : Scoreboard bench for rr_arb_4; grant episodes are queued by the
//            stimulus and checked by an independent negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_4;

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, req2, req3;
    logic done;
    logic g0, g1, g2, g3;
    logic busy, timeout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] g;
        int         len;
        logic       to;
    } ep_t;

    ep_t sb[$];

    rr_arb_4 #(
        .HOLD_MAX(16),
        .CNT_W   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .req2   (req2),
        .req3   (req3),
        .done   (done),
        .g0     (g0),
        .g1     (g1),
        .g2     (g2),
        .g3     (g3),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] g, input int len, input logic to);
        ep_t e;
        e.g   = g;
        e.len = len;
        e.to  = to;
        sb.push_back(e);
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    // Monitor: invariants every cycle, and one scoreboard pop per grant episode.
    logic [3:0] mon_gv;
    logic [3:0] mon_g    = 4'b0000;
    int         mon_len  = 0;
    logic       mon_prev = 1'b0;
    ep_t        mon_e;

    always @(negedge clk) begin
        mon_gv = {g3, g2, g1, g0};
        check("onehot0", 32'($onehot0(mon_gv)), 32'd1);
        check("busy_matches_grant", 32'(busy), 32'(|mon_gv));
        if (busy && !mon_prev) begin
            mon_g   = mon_gv;
            mon_len = 1;
        end else if (busy) begin
            mon_len++;
            check("grant_stable", 32'(mon_gv), 32'(mon_g));
        end else if (mon_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ep_unexpected: got grant %b len %0d, no episode queued", mon_g, mon_len);
            end else begin
                mon_e = sb.pop_front();
                check("ep_grant", 32'(mon_g), 32'(mon_e.g));
                check("ep_len", 32'(mon_len), 32'(mon_e.len));
                check("ep_timeout", 32'(timeout), 32'(mon_e.to));
            end
        end else begin
            check("no_stray_timeout", 32'(timeout), 32'd0);
        end
        mon_prev = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        {req3, req2, req1, req0} = 4'b1111;
        done = 1'b0;

        // Reset held two cycles with all requests high.
        step(2);
        check("rst_grant", 32'({g3, g2, g1, g0}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        {req3, req2, req1, req0} = 4'b0000;
        rst = 1'b0;
        step(1);

        // Single requester, done pulsed after 4 grant cycles, then re-grant.
        push(4'b0010, 4, 1'b0);
        push(4'b0010, 1, 1'b0);
        req1 = 1'b1;
        step(1);
        check("single_grant", 32'({g3, g2, g1, g0}), 32'b0010);
        check("single_enc", 32'(enc({g3, g2, g1, g0})), 32'd1);
        step(3);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("single_release", 32'({g3, g2, g1, g0}), 32'd0);
        step(1);
        check("single_regrant", 32'({g3, g2, g1, g0}), 32'b0010);
        req1 = 1'b0;
        step(1);
        check("single_drop", 32'({g3, g2, g1, g0}), 32'd0);

        // Fairness from ptr=0 with all four requesting.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        {req3, req2, req1, req0} = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push(4'b0001 << (i % 4), 1, 1'b0);
            step(1);
            check("fair_grant", 32'({g3, g2, g1, g0}), 32'(4'b0001 << (i % 4)));
            check("fair_enc", 32'(enc({g3, g2, g1, g0})), 32'(i % 4));
            done = 1'b1;
            step(1);
            done = 1'b0;
            check("fair_gap", 32'({g3, g2, g1, g0}), 32'd0);
        end

        // Timeout: owner 2 held 16 cycles, next grant goes to 3.
        {req3, req2, req1, req0} = 4'b1100;
        push(4'b0100, 16, 1'b1);
        push(4'b1000, 1, 1'b0);
        step(1);
        check("to_grant", 32'({g3, g2, g1, g0}), 32'b0100);
        step(16);
        check("to_release", 32'({g3, g2, g1, g0}), 32'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        step(1);
        check("to_next_owner", 32'({g3, g2, g1, g0}), 32'b1000);
        check("to_pulse_single", 32'(timeout), 32'd0);

        // Mid-grant reset, then ptr back at 0.
        rst = 1'b1;
        {req3, req2, req1, req0} = 4'b1010;
        step(1);
        check("midrst_grant", 32'({g3, g2, g1, g0}), 32'd0);
        check("midrst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        push(4'b0010, 1, 1'b0);
        step(1);
        check("midrst_regrant", 32'({g3, g2, g1, g0}), 32'b0010);
        done = 1'b1;
        step(1);
        done = 1'b0;
        {req3, req2, req1, req0} = 4'b0000;

        // done coincides with the last hold cycle: no timeout pulse.
        {req3, req2, req1, req0} = 4'b0001;
        push(4'b0001, 16, 1'b0);
        step(1);
        check("simul_grant", 32'({g3, g2, g1, g0}), 32'b0001);
        step(15);
        done = 1'b1;
        step(1);
        done = 1'b0;
        {req3, req2, req1, req0} = 4'b0000;
        check("simul_release", 32'({g3, g2, g1, g0}), 32'd0);
        check("simul_no_timeout", 32'(timeout), 32'd0);

        step(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
